// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage in front of the ADDU ALU: reads rs/rt from a
// 32x32 register file, decodes funct and holds the result in a one-entry output register.
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Src_1,
    output logic [DATA_W-1:0] Src_2,
    output logic [5:0]        ALU_ctrl,
    output logic [4:0]        Rd_addr,
    output logic              illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] regs_q [NREG];

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_rtype;
    logic       accept;
    logic       unused_shamt;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [5:0]        ctrl_q, ctrl_d;
    logic [4:0]        rdaddr_q, rdaddr_d;
    logic              illegal_q, illegal_d;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign is_rtype = (op == 6'd0);

    // The ALU has no shifter, so shamt is decoded by nobody.
    assign unused_shamt = ^instr[10:6];

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Write-first read: a same-edge writeback to the read index wins over the
    // stored value, and index 0 is hard-wired to zero.
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_a = regs_q[rs];
        if (rs == 5'd0) begin
            rd_a = '0;
        end else if (wb_en && (wb_addr == rs)) begin
            rd_a = wb_data;
        end

        rd_b = regs_q[rt];
        if (rt == 5'd0) begin
            rd_b = '0;
        end else if (wb_en && (wb_addr == rt)) begin
            rd_b = wb_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output data changes only on accept; draining to EMPTY keeps the last values.
    always_comb begin
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        rdaddr_d  = rdaddr_q;
        illegal_d = illegal_q;
        if (accept) begin
            src1_d    = rd_a;
            src2_d    = rd_b;
            ctrl_d    = is_rtype ? funct : 6'd0;
            rdaddr_d  = is_rtype ? rd : 5'd0;
            illegal_d = !is_rtype;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            rdaddr_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            rdaddr_q  <= rdaddr_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: the register file is cleared by reset, so it is built from flops
    // rather than a RAM macro; reset also drops any same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign Src_1    = src1_q;
    assign Src_2    = src2_q;
    assign ALU_ctrl = ctrl_q;
    assign Rd_addr  = rdaddr_q;
    assign illegal  = illegal_q;

endmodule
